// File: rtl/channel_in_acc_ctrl_pkg.sv
// Shared types and helpers for the channel-input accumulator controller.
package channel_in_acc_ctrl_pkg;

    // Widest lane-packed vector the per-lane adder accepts.
    localparam int MAX_VEC_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Tag carried alongside each beat while it travels through the adder tree.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_t;

    // Each lane holds the sum of two base-width products.
    function automatic int lane_width(input int width_data_out);
        return 2 * width_data_out;
    endfunction

    // Lane-wise modular add: the carry chain restarts at every lane boundary.
    function automatic logic [MAX_VEC_W-1:0] add_lanes(
        input logic [MAX_VEC_W-1:0] a,
        input logic [MAX_VEC_W-1:0] b,
        input int                   lane_w
    );
        logic [MAX_VEC_W-1:0] s;
        logic                 c;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < MAX_VEC_W; i++) begin
            if (i % lane_w == 0) c = 1'b0;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return s;
    endfunction

endpackage

// File: rtl/channel_in_acc_ctrl_acc_out_fifo.sv
// Small synchronous FIFO holding completed pixel sums; head is shown on dout.
module acc_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset because its head drives m_data, which must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/channel_in_acc_ctrl.sv
// Issues channel-group beats into the adder tree, tracks them through its
// latency, accumulates per-lane partial sums and queues finished pixels.
module channel_in_acc_ctrl
    import channel_in_acc_ctrl_pkg::*;
#(
    parameter int PICTURE_NUM    = 8,
    parameter int WIDTH_DATA_OUT = 16,
    parameter int TREE_LAT       = 4,
    parameter int OUT_DEPTH      = 4,
    parameter int CI_W           = 8,
    parameter int PIX_W          = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [CI_W-1:0]                       cfg_ci_times,
    input  logic [PIX_W-1:0]                      cfg_pix_num,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [PICTURE_NUM*WIDTH_DATA_OUT*2-1:0] tree_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [PICTURE_NUM*WIDTH_DATA_OUT*2-1:0] m_data,
    output logic                                  busy,
    output logic                                  done
);

    localparam int LANE_W = lane_width(WIDTH_DATA_OUT);
    localparam int DATA_W = PICTURE_NUM * LANE_W;
    localparam int CRED_W = $clog2(OUT_DEPTH + 1);

    state_e                     state_q, state_d;
    logic [CI_W-1:0]            ci_times_q, ci_cnt_q;
    logic [PIX_W-1:0]           pix_num_q, pix_cnt_q;
    logic [CRED_W-1:0]          credits_q;
    beat_t [TREE_LAT-1:0]       sr_q;
    beat_t                      head;
    logic                       sr_empty;
    logic [DATA_W-1:0]          acc_q, push_data_q, lane_sum;
    logic                       push_q;
    logic                       accept, pop, ci_last, pix_last;
    logic                       fifo_full, fifo_empty;

    assign ci_last  = (ci_cnt_q == ci_times_q - CI_W'(1));
    assign pix_last = (pix_cnt_q == pix_num_q - PIX_W'(1));
    // Only a pixel-closing beat needs a free FIFO slot reserved for it.
    assign s_ready  = (state_q == ST_RUN) && ((credits_q != '0) || !ci_last);
    assign accept   = s_valid && s_ready;
    assign pop      = m_valid && m_ready;
    assign m_valid  = !fifo_empty;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign head     = sr_q[TREE_LAT-1];
    assign lane_sum = DATA_W'(add_lanes(MAX_VEC_W'(acc_q), MAX_VEC_W'(tree_data), LANE_W));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: state_d gets a default first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (cfg_pix_num == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (accept && ci_last && pix_last) state_d = ST_DRAIN;
            ST_DRAIN: if (sr_empty && !push_q && fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Job configuration and channel-group / pixel counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ci_times_q <= '0;
            pix_num_q  <= '0;
            ci_cnt_q   <= '0;
            pix_cnt_q  <= '0;
        end else if (state_q == ST_IDLE && start) begin
            ci_times_q <= (cfg_ci_times == '0) ? CI_W'(1) : cfg_ci_times;
            pix_num_q  <= cfg_pix_num;
            ci_cnt_q   <= '0;
            pix_cnt_q  <= '0;
        end else if (accept) begin
            if (ci_last) begin
                ci_cnt_q  <= '0;
                pix_cnt_q <= pix_cnt_q + PIX_W'(1);
            end else begin
                ci_cnt_q  <= ci_cnt_q + CI_W'(1);
            end
        end
    end

    // Output-slot credits: reserved by a closing beat, returned by a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= CRED_W'(OUT_DEPTH);
        end else begin
            case ({accept && ci_last, pop})
                2'b10:   credits_q <= credits_q - CRED_W'(1);
                2'b01:   credits_q <= credits_q + CRED_W'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    // Beat tags delayed to line up with the tree output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= '{valid: accept, first: (ci_cnt_q == '0), last: ci_last};
            for (int i = 1; i < TREE_LAT; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    // True when no beat is still travelling through the tree.
    always_comb begin
        sr_empty = 1'b1;
        for (int i = 0; i < TREE_LAT; i++) if (sr_q[i].valid) sr_empty = 1'b0;
    end

    // Accumulate partial sums; a closing beat registers the pixel total for the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= head.valid && head.last;
            if (head.valid) begin
                if (head.last) push_data_q <= head.first ? tree_data : lane_sum;
                else           acc_q       <= head.first ? tree_data : lane_sum;
            end
        end
    end

    acc_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (push_data_q),
        .pop   (pop),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The credit scheme guarantees a slot for every pixel total.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_q && fifo_full && !pop));

endmodule
